hsiao_dec_pipe: RTL

Two-stage pipelined Hsiao (13,8) SEC-DED decoder with a valid/ready handshake on both sides. It consumes the 13-bit codewords that the Hsiao encoder produces, after they have been stored in and read back from protected memory. It returns the 8-bit data, correcting any single-bit error and flagging double or uncorrectable errors. Optional saturating error counters support scrub and health reporting.

---
 rtl/hsiao_dec_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hsiao_dec_pipe.sv
// Two-stage pipelined Hsiao (13,8) SEC-DED decoder with valid/ready on both sides.
// Define HSIAO_ERR_CNT_EN to add saturating corrected/uncorrectable error counters.
module hsiao_dec_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [12:0]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_sec,
    output logic             out_ded,
    output logic [4:0]       out_syn
`ifdef HSIAO_ERR_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sec_cnt,
    output logic [CNT_W-1:0] ded_cnt
`endif
);

    if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
        $error("hsiao_dec_pipe: CNT_W must be within 4..32");
    end

    function automatic logic [4:0] syndrome(input logic [12:0] code);
        logic [7:0] d;
        logic [4:0] c;
        d = code[12:5];
        c = code[4:0];
        syndrome[4] = c[4] ^ d[7] ^ d[6] ^ d[5] ^ d[4];
        syndrome[3] = c[3] ^ d[7] ^ d[3] ^ d[2] ^ d[1];
        syndrome[2] = c[2] ^ d[6] ^ d[5] ^ d[2] ^ d[1] ^ d[0];
        syndrome[1] = c[1] ^ d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];
        syndrome[0] = c[0] ^ d[7] ^ d[5] ^ d[4] ^ d[3] ^ d[2] ^ d[0];
    endfunction

    logic        v1_q, v1_d;
    logic        v2_q, v2_d;
    logic [12:0] code1_q;
    logic [4:0]  syn1_q;
    logic [7:0]  data2_q;
    logic        sec2_q, ded2_q;
    logic [4:0]  syn2_q;

    logic        load1, load2, out_hs;
    logic [7:0]  flip;
    logic        corr_sec, corr_ded;

    // in_ready is combinational from out_ready: a full pipe frees a slot in the same cycle it drains.
    assign in_ready = !v1_q || !v2_q || out_ready;
    assign load1    = in_valid && in_ready;
    assign load2    = v1_q && (!v2_q || out_ready);
    assign out_hs   = v2_q && out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        flip     = 8'h00;
        corr_sec = 1'b0;
        corr_ded = 1'b0;
        unique case (syn1_q)
            5'b00000: ;
            5'b11001: begin flip = 8'h80; corr_sec = 1'b1; end
            5'b10110: begin flip = 8'h40; corr_sec = 1'b1; end
            5'b10101: begin flip = 8'h20; corr_sec = 1'b1; end
            5'b10011: begin flip = 8'h10; corr_sec = 1'b1; end
            5'b01011: begin flip = 8'h08; corr_sec = 1'b1; end
            5'b01101: begin flip = 8'h04; corr_sec = 1'b1; end
            5'b01110: begin flip = 8'h02; corr_sec = 1'b1; end
            5'b00111: begin flip = 8'h01; corr_sec = 1'b1; end
            5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001: corr_sec = 1'b1;
            default:  corr_ded = 1'b1;
        endcase
        v1_d = load1 ? 1'b1 : (load2 ? 1'b0 : v1_q);
        v2_d = load2 ? 1'b1 : (out_hs ? 1'b0 : v2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    // NOTE: stage-1 payload has no reset; it is never observed unless v1_q is set.
    always_ff @(posedge clk) begin
        if (load1) begin
            code1_q <= in_code;
            syn1_q  <= syndrome(in_code);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data2_q <= 8'h00;
            sec2_q  <= 1'b0;
            ded2_q  <= 1'b0;
            syn2_q  <= 5'b00000;
        end else if (load2) begin
            data2_q <= corr_ded ? code1_q[12:5] : (code1_q[12:5] ^ flip);
            sec2_q  <= corr_sec;
            ded2_q  <= corr_ded;
            syn2_q  <= syn1_q;
        end
    end

    assign out_valid = v2_q;
    assign out_data  = data2_q;
    assign out_sec   = sec2_q;
    assign out_ded   = ded2_q;
    assign out_syn   = syn2_q;

`ifdef HSIAO_ERR_CNT_EN
    logic [CNT_W-1:0] sec_cnt_q, ded_cnt_q;

    // Counting on the handshake, not on v2_q, keeps a stalled word from being counted twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else if (cnt_clr) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else if (out_hs) begin
            if (sec2_q && sec_cnt_q != '1) sec_cnt_q <= sec_cnt_q + 1'b1;
            if (ded2_q && ded_cnt_q != '1) ded_cnt_q <= ded_cnt_q + 1'b1;
        end
    end

    assign sec_cnt = sec_cnt_q;
    assign ded_cnt = ded_cnt_q;
`endif

endmodule
